// File: rtl/elastic_context_controller_pkg.sv
// Shared types and constants for the elastic ALU context sequencer.
// Holds the controller state encoding, ALU opcode values and default widths.
package elastic_context_controller_pkg;

    localparam int DEF_DATA_WIDTH           = 32;
    localparam int DEF_OPERATION_BIT_LENGTH = 4;
    localparam int DEF_CONTEXT_DEPTH        = 8;
    localparam int DEF_CONTEXT_ADDR_WIDTH   = 3;
    localparam int DEF_ITER_WIDTH           = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_t;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_ADD    = 4'd1;
    localparam logic [3:0] OP_SUB    = 4'd2;
    localparam logic [3:0] OP_MUL    = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_CONST  = 4'd5;
    localparam logic [3:0] OP_LOAD   = 4'd6;
    localparam logic [3:0] OP_OUTPUT = 4'd7;
    localparam logic [3:0] OP_ROUTE  = 4'd8;

endpackage

// File: rtl/elastic_context_controller_context_memory.sv
// Context store: one write port, one combinational read port with write-first bypass.
// Every entry clears to {nop, 0} on reset.
module context_memory
    import elastic_context_controller_pkg::*;
#(
    parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
    parameter int OPERATION_BIT_LENGTH = DEF_OPERATION_BIT_LENGTH,
    parameter int CONTEXT_DEPTH        = DEF_CONTEXT_DEPTH,
    parameter int CONTEXT_ADDR_WIDTH   = DEF_CONTEXT_ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            write_enable,
    input  logic [CONTEXT_ADDR_WIDTH-1:0]   write_address,
    input  logic [OPERATION_BIT_LENGTH-1:0] write_op,
    input  logic [DATA_WIDTH-1:0]           write_const,
    input  logic [CONTEXT_ADDR_WIDTH-1:0]   read_address,
    output logic [OPERATION_BIT_LENGTH-1:0] read_op,
    output logic [DATA_WIDTH-1:0]           read_const
);

    logic [OPERATION_BIT_LENGTH-1:0] op_mem    [CONTEXT_DEPTH];
    logic [DATA_WIDTH-1:0]           const_mem [CONTEXT_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CONTEXT_DEPTH; i++) begin
                op_mem[i]    <= '0;
                const_mem[i] <= '0;
            end
        end else if (write_enable) begin
            op_mem[write_address]    <= write_op;
            const_mem[write_address] <= write_const;
        end
    end

    // Same-cycle write to the read address is forwarded so a start can see it.
    always_comb begin
        read_op    = op_mem[read_address];
        read_const = const_mem[read_address];
        if (write_enable && (write_address == read_address)) begin
            read_op    = write_op;
            read_const = write_const;
        end
    end

endmodule

// File: rtl/elastic_context_controller.sv
// Per-PE context sequencer: steps one elastic ALU through a programmed list of
// (op, const) contexts, advancing on each ALU switch_context pulse.
module elastic_context_controller
    import elastic_context_controller_pkg::*;
#(
    parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
    parameter int OPERATION_BIT_LENGTH = DEF_OPERATION_BIT_LENGTH,
    parameter int CONTEXT_DEPTH        = DEF_CONTEXT_DEPTH,
    parameter int CONTEXT_ADDR_WIDTH   = DEF_CONTEXT_ADDR_WIDTH,
    parameter int ITER_WIDTH           = DEF_ITER_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            config_write,
    input  logic [CONTEXT_ADDR_WIDTH-1:0]   config_address,
    input  logic [OPERATION_BIT_LENGTH-1:0] config_op,
    input  logic [DATA_WIDTH-1:0]           config_const,
    input  logic [CONTEXT_ADDR_WIDTH-1:0]   last_context,
    input  logic [ITER_WIDTH-1:0]           iteration_count,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            switch_context,
    output logic [OPERATION_BIT_LENGTH-1:0] op,
    output logic [DATA_WIDTH-1:0]           const_data,
    output logic                            start_exec,
    output logic [CONTEXT_ADDR_WIDTH-1:0]   context_index,
    output logic                            busy,
    output logic                            done,
    output ctrl_state_t                     state_dbg
);

    // ALU handshake: start_exec is a one-cycle pulse after an accepted start;
    // each single-cycle switch_context means the presented context has finished
    // and the next one is presented on the following cycle with no bubble.

    ctrl_state_t                     state, state_n;
    logic [CONTEXT_ADDR_WIDTH-1:0]   index_n, last_q, last_n;
    logic [ITER_WIDTH-1:0]           remaining_q, remaining_n;
    logic [OPERATION_BIT_LENGTH-1:0] op_n, read_op;
    logic [DATA_WIDTH-1:0]           const_n, read_const;
    logic                            start_exec_n, load_entry, mem_write;

    assign mem_write = config_write && (state != ST_RUN);
    assign state_dbg = state;

    context_memory #(
        .DATA_WIDTH           (DATA_WIDTH),
        .OPERATION_BIT_LENGTH (OPERATION_BIT_LENGTH),
        .CONTEXT_DEPTH        (CONTEXT_DEPTH),
        .CONTEXT_ADDR_WIDTH   (CONTEXT_ADDR_WIDTH)
    ) u_context_memory (
        .clk           (clk),
        .reset         (reset),
        .write_enable  (mem_write),
        .write_address (config_address),
        .write_op      (config_op),
        .write_const   (config_const),
        .read_address  (index_n),
        .read_op       (read_op),
        .read_const    (read_const)
    );

    always_comb begin
        state_n      = state;
        index_n      = context_index;
        last_n       = last_q;
        remaining_n  = remaining_q;
        start_exec_n = 1'b0;
        load_entry   = 1'b0;
        op_n         = op;
        const_n      = const_data;
        if (abort) begin
            state_n = ST_IDLE;
            index_n = '0;
            op_n    = OP_NOP;
            const_n = '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_n      = ST_RUN;
                        last_n       = last_context;
                        remaining_n  = iteration_count;
                        index_n      = '0;
                        start_exec_n = 1'b1;
                        load_entry   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (switch_context) begin
                        if (context_index != last_q) begin
                            index_n    = context_index + CONTEXT_ADDR_WIDTH'(1);
                            load_entry = 1'b1;
                        end else if (remaining_q != ITER_WIDTH'(1)) begin
                            // remaining == 0 is infinite mode and never decrements.
                            if (remaining_q != '0)
                                remaining_n = remaining_q - ITER_WIDTH'(1);
                            index_n    = '0;
                            load_entry = 1'b1;
                        end else begin
                            state_n = ST_DONE;
                            op_n    = OP_NOP;
                            const_n = '0;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    index_n = '0;
                    op_n    = OP_NOP;
                    const_n = '0;
                end
            endcase
            if (load_entry) begin
                op_n    = read_op;
                const_n = read_const;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            context_index <= '0;
            last_q        <= '0;
            remaining_q   <= '0;
            op            <= '0;
            const_data    <= '0;
            start_exec    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            context_index <= index_n;
            last_q        <= last_n;
            remaining_q   <= remaining_n;
            op            <= op_n;
            const_data    <= const_n;
            start_exec    <= start_exec_n;
            busy          <= (state_n == ST_RUN);
            done          <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_elastic_context_controller.sv
// Directed bench for elastic_context_controller: programs contexts, runs them
// and checks every registered output against hand-computed values.
module tb_elastic_context_controller;
    import elastic_context_controller_pkg::*;

    logic        clk;
    logic        reset;
    logic        config_write;
    logic [2:0]  config_address;
    logic [3:0]  config_op;
    logic [31:0] config_const;
    logic [2:0]  last_context;
    logic [15:0] iteration_count;
    logic        start;
    logic        abort;
    logic        switch_context;
    logic [3:0]  op;
    logic [31:0] const_data;
    logic        start_exec;
    logic [2:0]  context_index;
    logic        busy;
    logic        done;
    ctrl_state_t state_dbg;

    int total = 0;
    int bad   = 0;

    elastic_context_controller dut (
        .clk             (clk),
        .reset           (reset),
        .config_write    (config_write),
        .config_address  (config_address),
        .config_op       (config_op),
        .config_const    (config_const),
        .last_context    (last_context),
        .iteration_count (iteration_count),
        .start           (start),
        .abort           (abort),
        .switch_context  (switch_context),
        .op              (op),
        .const_data      (const_data),
        .start_exec      (start_exec),
        .context_index   (context_index),
        .busy            (busy),
        .done            (done),
        .state_dbg       (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] e_op, input logic [31:0] e_const,
                                 input logic [2:0] e_idx, input logic e_busy, input logic e_done);
        chk({tag, ".op"}, 32'(op), 32'(e_op));
        chk({tag, ".const"}, const_data, e_const);
        chk({tag, ".idx"}, 32'(context_index), 32'(e_idx));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
    endtask

    // driver tasks
    task automatic cfg_write(input logic [2:0] a, input logic [3:0] o, input logic [31:0] c);
        config_write = 1'b1; config_address = a; config_op = o; config_const = c;
        tick();
        config_write = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] last, input logic [15:0] iters);
        start = 1'b1; last_context = last; iteration_count = iters;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_switch();
        switch_context = 1'b1;
        tick();
        switch_context = 1'b0;
    endtask

    initial begin
        reset = 1'b1; config_write = 1'b0; config_address = '0; config_op = '0;
        config_const = '0; last_context = '0; iteration_count = '0;
        start = 1'b0; abort = 1'b0; switch_context = 1'b0;
        tick(); tick();
        check_outputs("reset", 4'd0, 32'd0, 3'd0, 1'b0, 1'b0);
        chk("reset.start_exec", 32'(start_exec), 32'd0);
        chk("reset.state", 32'(state_dbg), 32'(ST_IDLE));
        reset = 1'b0;
        tick();

        // basic three-context, single pass program
        cfg_write(3'd0, OP_ADD, 32'd0);
        cfg_write(3'd1, OP_CONST, 32'd7);
        cfg_write(3'd2, OP_ROUTE, 32'd0);
        check_outputs("idle_after_cfg", 4'd0, 32'd0, 3'd0, 1'b0, 1'b0);
        do_start(3'd2, 16'd1);
        check_outputs("t1_start", OP_ADD, 32'd0, 3'd0, 1'b1, 1'b0);
        chk("t1_start_exec_hi", 32'(start_exec), 32'd1);
        tick();
        chk("t1_start_exec_lo", 32'(start_exec), 32'd0);
        pulse_switch();
        check_outputs("t1_ctx1", OP_CONST, 32'd7, 3'd1, 1'b1, 1'b0);
        tick(); tick();
        pulse_switch();
        check_outputs("t1_ctx2", OP_ROUTE, 32'd0, 3'd2, 1'b1, 1'b0);
        tick(); tick();
        pulse_switch();
        check_outputs("t1_done", OP_NOP, 32'd0, 3'd2, 1'b0, 1'b1);
        tick();
        chk("t1_done_level", 32'(done), 32'd1);

        // two contexts, three passes, then an ignored extra pulse in DONE
        do_start(3'd1, 16'd3);
        check_outputs("t2_start", OP_ADD, 32'd0, 3'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            pulse_switch();
            chk($sformatf("t2_idx%0d", k), 32'(context_index), 32'(k % 2));
            chk($sformatf("t2_busy%0d", k), 32'(busy), 32'd1);
        end
        pulse_switch();
        check_outputs("t2_done", OP_NOP, 32'd0, 3'd1, 1'b0, 1'b1);
        pulse_switch();
        check_outputs("t2_ignored", OP_NOP, 32'd0, 3'd1, 1'b0, 1'b1);

        // infinite mode, then abort
        do_start(3'd2, 16'd0);
        for (int k = 1; k <= 20; k++) begin
            pulse_switch();
            chk($sformatf("t3_idx%0d", k), 32'(context_index), 32'(k % 3));
            chk($sformatf("t3_busy%0d", k), 32'(busy), 32'd1);
        end
        abort = 1'b1; switch_context = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; switch_context = 1'b0; start = 1'b0;
        check_outputs("t3_abort", OP_NOP, 32'd0, 3'd0, 1'b0, 1'b0);
        chk("t3_abort_state", 32'(state_dbg), 32'(ST_IDLE));

        // config write and start are ignored while running
        cfg_write(3'd1, OP_MUL, 32'd9);
        do_start(3'd2, 16'd0);
        pulse_switch();
        check_outputs("t4_mul", OP_MUL, 32'd9, 3'd1, 1'b1, 1'b0);
        cfg_write(3'd1, OP_DIV, 32'd99);
        do_start(3'd2, 16'd1);
        chk("t4_no_start_exec", 32'(start_exec), 32'd0);
        check_outputs("t4_start_ignored", OP_MUL, 32'd9, 3'd1, 1'b1, 1'b0);
        pulse_switch();
        pulse_switch();
        check_outputs("t4_wrap", OP_ADD, 32'd0, 3'd0, 1'b1, 1'b0);
        pulse_switch();
        check_outputs("t4_still_mul", OP_MUL, 32'd9, 3'd1, 1'b1, 1'b0);
        pulse_switch();
        check_outputs("t4_idx2", OP_ROUTE, 32'd0, 3'd2, 1'b1, 1'b0);

        // asynchronous reset mid-run clears outputs and the context store
        reset = 1'b1;
        #2;
        check_outputs("t5_async_reset", 4'd0, 32'd0, 3'd0, 1'b0, 1'b0);
        chk("t5_reset_start_exec", 32'(start_exec), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        do_start(3'd2, 16'd1);
        check_outputs("t5_cleared_entry0", OP_NOP, 32'd0, 3'd0, 1'b1, 1'b0);
        pulse_switch();
        check_outputs("t5_cleared_entry1", OP_NOP, 32'd0, 3'd1, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // same-edge write and start: write-first forwarding, single context repeated
        config_write = 1'b1; config_address = 3'd0; config_op = OP_CONST; config_const = 32'd42;
        do_start(3'd0, 16'd2);
        config_write = 1'b0;
        check_outputs("t6_fwd", OP_CONST, 32'd42, 3'd0, 1'b1, 1'b0);
        chk("t6_start_exec_hi", 32'(start_exec), 32'd1);
        tick();
        chk("t6_start_exec_lo", 32'(start_exec), 32'd0);
        pulse_switch();
        check_outputs("t6_repeat", OP_CONST, 32'd42, 3'd0, 1'b1, 1'b0);
        pulse_switch();
        check_outputs("t6_done", OP_NOP, 32'd0, 3'd0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elastic_context_controller.md
# elastic_context_controller

Per-PE context sequencer that configures and steps one elastic ALU through a small program of (op, const) contexts. It holds a CONTEXT_DEPTH-entry context store loaded over a config port, then on `start` drives `op`/`const_data` for context 0. It issues the ALU `start_exec` pulse and advances to the next context on every ALU `switch_context` pulse. After the programmed number of iterations it parks the ALU on nop and raises `done`.

## Interface
- DATA_WIDTH, 32, datapath and const width
- OPERATION_BIT_LENGTH, 4, opcode width
- CONTEXT_DEPTH, 8, number of context entries (power of two, ≥2)
- CONTEXT_ADDR_WIDTH, 3, log2(CONTEXT_DEPTH)
- ITER_WIDTH, 16, iteration counter width
- One clock; reset is asynchronous and active-high. Ports are named `clk` and `reset`.
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- config_write  in  1  write context entry (accepted only in IDLE/DONE)
- config_address  in  CONTEXT_ADDR_WIDTH  entry index
- config_op  in  OPERATION_BIT_LENGTH  opcode to store
- config_const  in  DATA_WIDTH  constant to store
- last_context  in  CONTEXT_ADDR_WIDTH  index of final context, sampled on accepted `start`
- iteration_count  in  ITER_WIDTH  program passes, sampled on accepted `start`; 0 = run forever
- start  in  1  begin run (accepted only in IDLE/DONE)
- abort  in  1  return to IDLE immediately
- switch_context  in  1  ALU completion pulse
- op  out  OPERATION_BIT_LENGTH  opcode to ALU, registered
- const_data  out  DATA_WIDTH  constant to ALU, registered
- start_exec  out  1  one-cycle ALU start pulse
- context_index  out  CONTEXT_ADDR_WIDTH  current context
- busy  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE:
  - `op`=0 (nop) and `const_data`=0.
  - `config_write` stores {config_op, config_const} at `config_address`.
- IDLE/DONE + `start` → RUN:
  - Latch `last_context` and `iteration_count`; set `context_index`=0.
  - Load `op`/`const_data` from entry 0.
  - Pulse `start_exec` for exactly the cycle after the `start` edge.
  - `done` clears on the transition.
- RUN + `switch_context`, `context_index` < last: index+1; load that entry.
- RUN + `switch_context`, `context_index` == last:
  - Infinite mode, or remaining passes > 1: decrement remaining (not in infinite mode), index → 0, load entry 0.
  - Remaining == 1: → DONE; `op`/`const_data` → 0; index holds last.
- `last_context`=0 is legal: one context repeated, one pass per `switch_context`.
- `abort` (any state) → IDLE, `op`/`const_data` → 0, index 0, `done` 0. `abort` has priority over `start` and `switch_context`.
- Ignored inputs:
  - `config_write` while in RUN: no store.
  - `start` while in RUN.
  - `switch_context` outside RUN.
- `start` with simultaneous `config_write`: the write lands first; entry 0 is read after the write, so the new value is visible.
- Reset:
  - state IDLE; `op` 0, `const_data` 0, `start_exec` 0, `context_index` 0, `busy` 0, `done` 0.
  - All context entries cleared to {0, 0}; remaining counter 0.

## Timing
- All outputs are registered.
- `switch_context` at edge N → new `op`/`const_data`/`context_index` valid after edge N, i.e. in the cycle following the pulse; no bubble cycles.
- `start` at edge N → `busy`=1 and entry-0 outputs after N; `start_exec`=1 for cycle N..N+1 only.
- Final `switch_context` at edge N → `done`=1, `busy`=0 after N.
- `done` is a level and holds until `start` or `abort`.
- Config write latency: 1 cycle. An entry written at edge N is readable by a `start` at edge N, via write-first forwarding.
- Iteration counter width: ITER_WIDTH unsigned, with no wrap. The decrement occurs only on the last-context switch.

## Structure
- Shared package contents:
  - State encoding (IDLE/RUN/DONE).
  - Opcode constants OP_NOP=0, OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_DIV=4, OP_CONST=5, OP_LOAD=6, OP_OUTPUT=7, OP_ROUTE=8.
  - Default widths.
- Sub-module `context_memory`: CONTEXT_DEPTH × (OPERATION_BIT_LENGTH+DATA_WIDTH) register file. It has one write port, one combinational read port, write-first bypass, and async clear on `reset`.
- The controller FSM, index counter and iteration counter live in the top module.

## Test plan
- Load entries 0..2 = {ADD,0},{CONST,7},{ROUTE,0}; last=2, iter=1; start; three `switch_context` pulses spaced 3 cycles → `op` sequence 1,5,8, `const_data` 7 on entry 1, then `done`=1, `op`=0.
- last=1, iter=3: six pulses → `context_index` 0,1,0,1,0,1, then DONE after sixth; a seventh pulse causes no change.
- iter=0: 20 pulses with last=2 → `busy` stays 1, index cycles mod 3; `abort` → IDLE, `op`=0, `done`=0.
- `config_write` during RUN to entry 1 with OP_DIV → entry unchanged (MUL still presented next pass); `start` during RUN → no `start_exec` pulse.
- Reset asserted mid-RUN at index 2 → all outputs 0 asynchronously; start after release with no reloads → `op`=0 (entries cleared).
- Same-edge `config_write` entry 0 = {CONST,42} and `start` → first presented `op`=5, `const_data`=42, `start_exec` single-cycle.
